// File: rtl/cfg_loop_pkg.sv
// cfg_loop_pkg: shared types and constants for the channel sweep sequencer
package cfg_loop_pkg;
    localparam int CH_W = 5;
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_WAIT   = 3'd2,
        S_GAP    = 3'd3,
        S_FINISH = 3'd4
    } cfg_loop_state_e;
    typedef enum logic [1:0] {
        ST_OK        = 2'b00,
        ST_BAD_RANGE = 2'b01,
        ST_TIMEOUT   = 2'b10,
        ST_ABORTED   = 2'b11
    } cfg_loop_status_e;
endpackage

// File: rtl/cfg_loop_watchdog.sv
// cfg_loop_watchdog: clearable up-counter flagging the last cycle of a limit-cycle window
module cfg_loop_watchdog #(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic         expired
);
    logic [W-1:0] cnt_q, cnt_d;
    // count enabled cycles since the last clear
    always_comb cnt_d = clr ? '0 : (en ? cnt_q + W'(1) : cnt_q);
    // counter register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    assign expired = en && (cnt_q == limit - W'(1));
endmodule

// File: rtl/cfg_loop_ctrl.sv
// cfg_loop_ctrl: sweeps i_m1 over a range, one watchdog-guarded triple-write sequence per channel
module cfg_loop_ctrl
    import cfg_loop_pkg::*;
#(
    parameter int NUM_CH         = 24,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic [CH_W-1:0] first_ch,
    input  logic [CH_W-1:0] last_ch,
    output logic            busy,
    output logic            done,
    output logic [1:0]      status,
    output logic [5:0]      ch_count,
    output logic            start_three_writes,
    input  logic            three_writes_done,
    output logic [CH_W-1:0] i_m1_val
);
    localparam int WD_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
    localparam int WD_W   = $clog2(WD_MAX + 1);

    cfg_loop_state_e  state_q, state_d;
    cfg_loop_status_e status_q, status_d;
    logic [CH_W-1:0]  cur_ch_q, cur_ch_d, last_q, last_d;
    logic [5:0]       ch_count_q, ch_count_d;
    logic             busy_q, done_q, stw_q;
    logic             wd_expired;
    logic             bad_range;

    assign bad_range = (first_ch > last_ch) || (32'(last_ch) >= NUM_CH);

    // one counter serves both the WAIT watchdog and the GAP delay; it restarts on every state change
    cfg_loop_watchdog #(.W(WD_W)) u_wd (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (state_d != state_q),
        .en      ((state_q == S_WAIT) || (state_q == S_GAP)),
        .limit   (WD_W'((state_q == S_GAP) ? GAP_CYCLES : TIMEOUT_CYCLES)),
        .expired (wd_expired)
    );

    // sweep FSM: a done in WAIT takes priority over the watchdog, abort only acts at sequence boundaries
    always_comb begin
        state_d    = state_q;
        status_d   = status_q;
        cur_ch_d   = cur_ch_q;
        last_d     = last_q;
        ch_count_d = ch_count_q;
        case (state_q)
            S_IDLE: if (start) begin
                last_d     = last_ch;
                ch_count_d = '0;
                status_d   = bad_range ? ST_BAD_RANGE : ST_OK;
                state_d    = bad_range ? S_FINISH : S_ISSUE;
                cur_ch_d   = bad_range ? cur_ch_q : first_ch;
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: if (three_writes_done) begin
                ch_count_d = ch_count_q + 6'd1;
                if (abort) begin
                    state_d  = S_FINISH;
                    status_d = ST_ABORTED;
                end else if (cur_ch_q == last_q) begin
                    state_d  = S_FINISH;
                    status_d = ST_OK;
                end else begin
                    cur_ch_d = cur_ch_q + CH_W'(1);
                    state_d  = (GAP_CYCLES == 0) ? S_ISSUE : S_GAP;
                end
            end else if (wd_expired) begin
                state_d  = S_FINISH;
                status_d = ST_TIMEOUT;
            end
            S_GAP: begin
                state_d  = abort ? S_FINISH : (wd_expired ? S_ISSUE : S_GAP);
                status_d = abort ? ST_ABORTED : status_q;
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // state and registered outputs, derived from the next state so they line up with it
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q    <= S_IDLE;
            status_q   <= ST_OK;
            cur_ch_q   <= '0;
            last_q     <= '0;
            ch_count_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            stw_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            status_q   <= status_d;
            cur_ch_q   <= cur_ch_d;
            last_q     <= last_d;
            ch_count_q <= ch_count_d;
            busy_q     <= state_d != S_IDLE;
            done_q     <= state_d == S_FINISH;
            stw_q      <= state_d == S_ISSUE;
        end

    assign busy               = busy_q;
    assign done               = done_q;
    assign status             = status_q;
    assign ch_count           = ch_count_q;
    assign start_three_writes = stw_q;
    assign i_m1_val           = cur_ch_q;
endmodule
